mem_port_arbiter: RTL and testbench

Sequencing arbiter that shares the single backing-memory port between the instruction-fetch side and the data side of the 3-stage RISC-V core. It accepts at most one transaction at a time, issues it on the memory port with a valid/ready handshake, and routes the response to the requester that owns it. Data requests have priority. A starvation counter guarantees forward progress for instruction fetch.

---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the instruction-fetch requester, the data requester,
// the backing-memory port and the arbiter that shares that port.
// The arbiter connects through the slave modport.
// The environment (requesters plus memory) connects through the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // instruction-fetch side
  logic                  ic_req_valid;
  logic                  ic_req_ready;
  logic [ADDR_WIDTH-1:0] ic_req_addr;
  logic                  ic_resp_valid;
  logic [DATA_WIDTH-1:0] ic_resp_data;

  // data side
  logic                  dc_req_valid;
  logic                  dc_req_ready;
  logic                  dc_req_rw;
  logic [ADDR_WIDTH-1:0] dc_req_addr;
  logic [DATA_WIDTH-1:0] dc_req_wdata;
  logic [3:0]            dc_req_wmask;
  logic                  dc_resp_valid;
  logic [DATA_WIDTH-1:0] dc_resp_data;

  // backing-memory port
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_rw;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [3:0]            mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  // owner of the current transaction (1 = data side)
  logic                  grant_dc;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_ready, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output grant_dc
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_ready, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  grant_dc
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single backing-memory port between instruction fetch and the
// data side. One transaction is in flight at a time: accept, issue, wait.
// Data requests win ties unless instruction fetch has already been passed
// over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [1:0]            state_r;
  logic [3:0]            starve_cnt_r;
  logic                  owner_dc_r;
  logic                  mem_req_valid_r;
  logic                  mem_rw_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [3:0]            mem_wmask_r;
  logic                  ic_resp_valid_r;
  logic [DATA_WIDTH-1:0] ic_resp_data_r;
  logic                  dc_resp_valid_r;
  logic [DATA_WIDTH-1:0] dc_resp_data_r;

  logic                  grant_ic_s;
  logic                  grant_dc_s;
  logic [3:0]            starve_nxt_s;

  // Pick a requester in IDLE; the data side wins unless fetch has hit its starvation limit.
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (!reset && (state_r == ST_IDLE)) begin
      if (bus.dc_req_valid && !(bus.ic_req_valid && (starve_cnt_r == LIMIT_C))) begin
        grant_dc_s = 1'b1;
      end else if (bus.ic_req_valid) begin
        grant_ic_s = 1'b1;
      end else begin
        grant_ic_s = 1'b0;
        grant_dc_s = 1'b0;
      end
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  // Count data grants that passed over a waiting fetch; any other grant clears it.
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (grant_ic_s) begin
      starve_nxt_s = 4'd0;
    end else if (grant_dc_s) begin
      if (!bus.ic_req_valid) begin
        starve_nxt_s = 4'd0;
      end else if (starve_cnt_r >= LIMIT_C) begin
        starve_nxt_s = LIMIT_C;
      end else begin
        starve_nxt_s = starve_cnt_r + 4'd1;
      end
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Transaction sequencer: latch the granted request, hold it on the memory port, route the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      starve_cnt_r    <= 4'd0;
      owner_dc_r      <= 1'b0;
      mem_req_valid_r <= 1'b0;
      mem_rw_r        <= 1'b0;
      mem_addr_r      <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r     <= {DATA_WIDTH{1'b0}};
      mem_wmask_r     <= 4'd0;
      ic_resp_valid_r <= 1'b0;
      ic_resp_data_r  <= {DATA_WIDTH{1'b0}};
      dc_resp_valid_r <= 1'b0;
      dc_resp_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      ic_resp_valid_r <= 1'b0;
      dc_resp_valid_r <= 1'b0;
      starve_cnt_r    <= starve_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_dc_s) begin
            owner_dc_r      <= 1'b1;
            mem_rw_r        <= bus.dc_req_rw;
            mem_addr_r      <= bus.dc_req_addr;
            mem_wdata_r     <= bus.dc_req_wdata;
            mem_wmask_r     <= bus.dc_req_wmask;
            mem_req_valid_r <= 1'b1;
            state_r         <= ST_ISSUE;
          end else if (grant_ic_s) begin
            owner_dc_r      <= 1'b0;
            mem_rw_r        <= 1'b0;
            mem_addr_r      <= bus.ic_req_addr;
            mem_wdata_r     <= {DATA_WIDTH{1'b0}};
            mem_wmask_r     <= 4'd0;
            mem_req_valid_r <= 1'b1;
            state_r         <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // responses arriving before the memory accepted the request are ignored
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state_r         <= ST_WAIT;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (bus.mem_resp_valid) begin
            if (owner_dc_r) begin
              dc_resp_valid_r <= 1'b1;
              // writes complete with zero data whatever the memory returns
              dc_resp_data_r  <= mem_rw_r ? {DATA_WIDTH{1'b0}} : bus.mem_resp_data;
            end else begin
              ic_resp_valid_r <= 1'b1;
              ic_resp_data_r  <= bus.mem_resp_data;
            end
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          mem_req_valid_r <= 1'b0;
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ic_req_ready  = grant_ic_s;
  assign bus.dc_req_ready  = grant_dc_s;
  assign bus.ic_resp_valid = ic_resp_valid_r;
  assign bus.ic_resp_data  = ic_resp_data_r;
  assign bus.dc_resp_valid = dc_resp_valid_r;
  assign bus.dc_resp_data  = dc_resp_data_r;
  assign bus.mem_req_valid = mem_req_valid_r;
  assign bus.mem_req_rw    = mem_rw_r;
  assign bus.mem_req_addr  = mem_addr_r;
  assign bus.mem_req_wdata = mem_wdata_r;
  assign bus.mem_req_wmask = mem_wmask_r;
  assign bus.grant_dc      = owner_dc_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. The env process plays both
// requesters and the memory and keeps a transaction-level reference model.
// The monitor process pops expected responses from a queue and compares them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int NCYC  = 3000;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        owner_dc;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h0000_2000;
    return base + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  // model state (env process only)
  int          phase;      // 0 idle, 1 request on memory port, 2 waiting for memory data
  int          starve;
  logic        owner;
  logic        exp_rw;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wmask;
  int          resp_cnt;
  logic [31:0] resp_data_pending;
  bit          resp_now, pulse_ic_due, pulse_dc_due, chk_rst_vals;
  bit          ic_acc, dc_acc, want_reset, no_d;
  int          hold_cnt, p_i, p_d;

  initial begin : env
    bit do_reset, g_ic, g_dc;
    reset = 1'b1;
    bus.ic_req_valid = 1'b0; bus.ic_req_addr = 32'd0;
    bus.dc_req_valid = 1'b0; bus.dc_req_rw = 1'b0; bus.dc_req_addr = 32'd0;
    bus.dc_req_wdata = 32'd0; bus.dc_req_wmask = 4'd0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'd0;
    ref_mem[32'h0000_1000] = 32'hDEAD_BEEF;
    env_mem[32'h0000_1000] = 32'hDEAD_BEEF;
    phase = 0; starve = 0; owner = 1'b0; resp_cnt = 0; hold_cnt = 0;
    exp_rw = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_wmask = 4'd0;
    resp_data_pending = 32'd0;
    resp_now = 0; pulse_ic_due = 0; pulse_dc_due = 0; chk_rst_vals = 0;
    ic_acc = 0; dc_acc = 0; want_reset = 0; no_d = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // ---------------- drive phase ----------------
      @(posedge clk); #1;
      if (cyc < 20) begin p_i = 0; p_d = 0; end
      else if (cyc >= 400 && cyc < 700) begin p_i = 100; p_d = 100; end
      else if (cyc >= NCYC - 150) begin p_i = 0; p_d = 0; end
      else begin p_i = 30; p_d = 40; end
      if (cyc == 900 || cyc == 1600 || cyc == 2300) want_reset = 1;
      if (cyc == 50) hold_cnt = 5;

      do_reset = (cyc < 3);
      if (!do_reset && want_reset && phase == 2 && resp_cnt > 1) begin
        do_reset = 1; want_reset = 0;
      end
      reset = do_reset;

      // memory responder
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
      resp_now = 0;
      if (!do_reset && phase == 2) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = resp_data_pending;
          resp_now = 1;
        end
      end else if (!do_reset && $urandom_range(0, 5) == 0) begin
        bus.mem_resp_valid = 1'b1;  // spurious: memory is not in the data phase
      end
      if (hold_cnt > 0) begin
        hold_cnt--;
        bus.mem_req_ready = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        hold_cnt = 4;
        bus.mem_req_ready = 1'b0;
      end else begin
        bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      end

      // requesters
      if (ic_acc) begin bus.ic_req_valid = 1'b0; ic_acc = 0; end
      if (dc_acc) begin bus.dc_req_valid = 1'b0; dc_acc = 0; end
      if (do_reset) begin
        bus.dc_req_valid = 1'b0;
        if (cyc >= 3) begin
          if (!bus.ic_req_valid) bus.ic_req_addr = rand_addr();
          bus.ic_req_valid = 1'b1;
          no_d = 1;
        end
      end else begin
        if (cyc == 3) begin
          bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h0000_1000;
        end
        if (cyc == 12) begin
          bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b1; bus.dc_req_addr = 32'h0000_2004;
          bus.dc_req_wdata = 32'h0000_00AB; bus.dc_req_wmask = 4'b0001;
        end
        if (!bus.ic_req_valid && $urandom_range(0, 99) < p_i) begin
          bus.ic_req_valid = 1'b1; bus.ic_req_addr = rand_addr();
        end
        if (!no_d && !bus.dc_req_valid && $urandom_range(0, 99) < p_d) begin
          bus.dc_req_valid = 1'b1;
          bus.dc_req_rw    = 1'($urandom_range(0, 1));
          bus.dc_req_addr  = rand_addr();
          bus.dc_req_wdata = $urandom;
          bus.dc_req_wmask = 4'($urandom_range(0, 15));
        end
        no_d = 0;
      end

      // ---------------- sample phase ----------------
      @(negedge clk);
      if (reset) begin
        check("ic_ready_in_reset", {63'd0, bus.ic_req_ready}, 64'd0);
        check("dc_ready_in_reset", {63'd0, bus.dc_req_ready}, 64'd0);
        exp_q.delete();
        phase = 0; starve = 0; owner = 1'b0; resp_cnt = 0;
        pulse_ic_due = 0; pulse_dc_due = 0; chk_rst_vals = 1;
      end else begin
        if (chk_rst_vals) begin
          check("rst_mem_addr",  bus.mem_req_addr, 64'd0);
          check("rst_mem_wdata", bus.mem_req_wdata, 64'd0);
          check("rst_mem_wmask", bus.mem_req_wmask, 64'd0);
          check("rst_mem_rw",    bus.mem_req_rw, 64'd0);
          check("rst_ic_data",   bus.ic_resp_data, 64'd0);
          check("rst_dc_data",   bus.dc_resp_data, 64'd0);
          chk_rst_vals = 0;
        end
        check("ic_resp_pulse", bus.ic_resp_valid, pulse_ic_due);
        check("dc_resp_pulse", bus.dc_resp_valid, pulse_dc_due);
        pulse_ic_due = 0; pulse_dc_due = 0;
        check("mem_req_valid", bus.mem_req_valid, (phase == 1));
        if (phase == 1) begin
          check("mem_req_rw",   bus.mem_req_rw, exp_rw);
          check("mem_req_addr", bus.mem_req_addr, exp_addr);
          if (owner) begin
            check("mem_req_wdata", bus.mem_req_wdata, exp_wdata);
            check("mem_req_wmask", bus.mem_req_wmask, exp_wmask);
          end
        end
        check("grant_dc", bus.grant_dc, owner);

        g_dc = (phase == 0) && bus.dc_req_valid && !(bus.ic_req_valid && starve == LIMIT);
        g_ic = (phase == 0) && !g_dc && bus.ic_req_valid;
        check("ic_req_ready", bus.ic_req_ready, g_ic);
        check("dc_req_ready", bus.dc_req_ready, g_dc);

        if (g_dc) begin
          starve = bus.ic_req_valid ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
          owner = 1'b1; exp_rw = bus.dc_req_rw; exp_addr = bus.dc_req_addr;
          exp_wdata = bus.dc_req_wdata; exp_wmask = bus.dc_req_wmask;
          if (exp_rw) begin
            ref_mem[exp_addr] = merge(ref_read(exp_addr), exp_wdata, exp_wmask);
            exp_q.push_back({1'b1, 32'd0});
          end else begin
            exp_q.push_back({1'b1, ref_read(exp_addr)});
          end
          phase = 1; dc_acc = 1;
        end else if (g_ic) begin
          starve = 0; owner = 1'b0; exp_rw = 1'b0; exp_addr = bus.ic_req_addr;
          exp_q.push_back({1'b0, ref_read(exp_addr)});
          phase = 1; ic_acc = 1;
        end else if (phase == 1 && bus.mem_req_ready) begin
          if (bus.mem_req_rw) begin
            env_mem[bus.mem_req_addr] = merge(env_read(bus.mem_req_addr), bus.mem_req_wdata,
                                              bus.mem_req_wmask);
            resp_data_pending = $urandom;
          end else begin
            resp_data_pending = env_read(bus.mem_req_addr);
          end
          resp_cnt = $urandom_range(1, 4);
          phase = 2;
        end else if (phase == 2 && resp_now) begin
          phase = 0;
          if (owner) pulse_dc_due = 1; else pulse_ic_due = 1;
        end
      end
    end

    @(negedge clk);
    check("queue_drained", exp_q.size(), 64'd0);
    check("model_idle", phase, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : monitor
    logic [31:0] last_ic, last_dc;
    bit          rst_prev;
    exp_t        e;
    last_ic = 32'd0; last_dc = 32'd0; rst_prev = 0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin last_ic = 32'd0; last_dc = 32'd0; end
      if (!reset) begin
        if (bus.ic_resp_valid) begin
          if (exp_q.size() == 0) begin
            check("ic_resp_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("ic_resp_owner", 64'd0, e.owner_dc);
            check("ic_resp_data", bus.ic_resp_data, e.data);
          end
          last_ic = bus.ic_resp_data;
        end else begin
          check("ic_resp_hold", bus.ic_resp_data, last_ic);
        end
        if (bus.dc_resp_valid) begin
          if (exp_q.size() == 0) begin
            check("dc_resp_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("dc_resp_owner", 64'd1, e.owner_dc);
            check("dc_resp_data", bus.dc_resp_data, e.data);
          end
          last_dc = bus.dc_resp_data;
        end else begin
          check("dc_resp_hold", bus.dc_resp_data, last_dc);
        end
      end
      rst_prev = reset;
    end
  end

endmodule
